// File: rtl/lf_align_pkg.sv
// Shared types and constants for the LF beam delay alignment stage.
package lf_align_pkg;
  localparam int LF_NSAMP    = 4;
  localparam int LF_NBITS    = 5;
  localparam int LF_DEPTH    = 22;
  localparam int LF_MAX_DLY  = (LF_DEPTH-1)*LF_NSAMP;
  localparam int LF_DLY_BITS = $clog2(LF_MAX_DLY+1);

  typedef logic [LF_NBITS-1:0]          sample_t;
  typedef logic [LF_NSAMP*LF_NBITS-1:0] chan_word_t;
  typedef logic [LF_DLY_BITS-1:0]       dly_t;

  // Offset-binary zero level, used for channels switched out of a beam.
  function automatic int unsigned lf_mid(input int unsigned nbits);
    return 32'd1 << (nbits - 1);
  endfunction
endpackage

// File: rtl/lf_align_cfg.sv
// Shadow/active configuration registers: per-beam/channel delays and
// per-beam use/invert masks, with atomic update and sticky error flag.
module lf_align_cfg
  import lf_align_pkg::*;
#(
  parameter int NBEAMS   = 2,
  parameter int NCHAN    = 8,
  parameter int DLY_BITS = 7,
  parameter int MAX_DLY  = 84,
  parameter int BA_BITS  = 1,
  parameter int CA_BITS  = 3
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     dly_wr_i,
  input  logic [BA_BITS-1:0]                       dly_beam_i,
  input  logic [CA_BITS-1:0]                       dly_chan_i,
  input  logic [DLY_BITS-1:0]                      dly_data_i,
  input  logic                                     mask_wr_i,
  input  logic [NCHAN-1:0]                         mask_use_i,
  input  logic [NCHAN-1:0]                         mask_inv_i,
  input  logic                                     update_i,
  input  logic                                     err_clr_i,
  output logic [NBEAMS-1:0][NCHAN-1:0][DLY_BITS-1:0] dly_o,
  output logic [NBEAMS-1:0][NCHAN-1:0]             use_o,
  output logic [NBEAMS-1:0][NCHAN-1:0]             inv_o,
  output logic                                     err_o
);
  logic [NBEAMS-1:0][NCHAN-1:0][DLY_BITS-1:0] r_sh_dly, r_dly;
  logic [NBEAMS-1:0][NCHAN-1:0]               r_sh_use, r_use, r_sh_inv, r_inv;
  logic                                       r_err;
  logic                                       w_beam_ok, w_chan_ok, w_over, w_err;
  logic [DLY_BITS-1:0]                        w_dly_clamp;

  // Address checks only exist when the field can encode unused entries.
  if (NBEAMS == (1 << BA_BITS)) begin : g_bfull
    assign w_beam_ok = 1'b1;
  end else begin : g_bchk
    assign w_beam_ok = (dly_beam_i < BA_BITS'(NBEAMS));
  end
  if (NCHAN == (1 << CA_BITS)) begin : g_cfull
    assign w_chan_ok = 1'b1;
  end else begin : g_cchk
    assign w_chan_ok = (dly_chan_i < CA_BITS'(NCHAN));
  end

  assign w_over      = (dly_data_i > DLY_BITS'(MAX_DLY));
  assign w_dly_clamp = w_over ? DLY_BITS'(MAX_DLY) : dly_data_i;
  assign w_err       = (dly_wr_i && (!w_beam_ok || !w_chan_ok || w_over)) ||
                       (mask_wr_i && !w_beam_ok);

  // Update copies the pre-write shadow: the NBA reads old shadow values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sh_dly <= '0;
      r_dly    <= '0;
      r_sh_use <= '1;
      r_use    <= '1;
      r_sh_inv <= '0;
      r_inv    <= '0;
      r_err    <= 1'b0;
    end else begin
      if (update_i) begin
        r_dly <= r_sh_dly;
        r_use <= r_sh_use;
        r_inv <= r_sh_inv;
      end
      if (dly_wr_i && w_beam_ok && w_chan_ok)
        r_sh_dly[dly_beam_i][dly_chan_i] <= w_dly_clamp;
      if (mask_wr_i && w_beam_ok) begin
        r_sh_use[dly_beam_i] <= mask_use_i;
        r_sh_inv[dly_beam_i] <= mask_inv_i;
      end
      if (w_err)          r_err <= 1'b1;
      else if (err_clr_i) r_err <= 1'b0;
    end
  end

  assign dly_o = r_dly;
  assign use_o = r_use;
  assign inv_o = r_inv;
  assign err_o = r_err;
endmodule

// File: rtl/lf_beam_delay_align.sv
// Per-channel sample history feeding NBEAMS delay-aligned, masked copies
// of the input channels through a registered variable-offset mux.
module lf_beam_delay_align
  import lf_align_pkg::*;
#(
  parameter  int NBEAMS   = 2,
  parameter  int NCHAN    = 8,
  parameter  int NSAMP    = 4,
  parameter  int NBITS    = 5,
  parameter  int DEPTH    = 22,
  localparam int MAX_DLY  = (DEPTH-1)*NSAMP,
  localparam int DLY_BITS = $clog2(MAX_DLY+1),
  localparam int BA_BITS  = (NBEAMS > 1) ? $clog2(NBEAMS) : 1,
  localparam int CA_BITS  = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic [NCHAN-1:0][NSAMP*NBITS-1:0]             data_i,
  input  logic                                          dly_wr_i,
  input  logic [BA_BITS-1:0]                            dly_beam_i,
  input  logic [CA_BITS-1:0]                            dly_chan_i,
  input  logic [DLY_BITS-1:0]                           dly_data_i,
  input  logic                                          mask_wr_i,
  input  logic [NCHAN-1:0]                              mask_use_i,
  input  logic [NCHAN-1:0]                              mask_inv_i,
  input  logic                                          update_i,
  input  logic                                          err_clr_i,
  output logic [NBEAMS-1:0][NCHAN-1:0][NSAMP*NBITS-1:0] beams_o,
  output logic                                          valid_o,
  output logic                                          err_o
);
  localparam int WW        = NSAMP*NBITS;
  localparam int NAGE      = DEPTH*NSAMP;
  localparam int AGE_BITS  = $clog2(NAGE);
  localparam int FILL_BITS = $clog2(DEPTH+2);
  localparam logic [NBITS-1:0]     MID  = NBITS'(lf_mid(NBITS));
  localparam logic [FILL_BITS-1:0] FULL = FILL_BITS'(DEPTH+1);

  logic [NCHAN-1:0][DEPTH-1:0][WW-1:0]          r_hist;
  logic [NCHAN-1:0][NAGE-1:0][NBITS-1:0]        w_age;
  logic [NBEAMS-1:0][NCHAN-1:0][DLY_BITS-1:0]   w_dly;
  logic [NBEAMS-1:0][NCHAN-1:0]                 w_use, w_inv;
  logic [NBEAMS-1:0][NCHAN-1:0][WW-1:0]         w_mux;
  logic [NBEAMS-1:0][NCHAN-1:0][WW-1:0]         r_beams;
  logic [FILL_BITS-1:0]                         r_fill;

  lf_align_cfg #(
    .NBEAMS(NBEAMS), .NCHAN(NCHAN), .DLY_BITS(DLY_BITS), .MAX_DLY(MAX_DLY),
    .BA_BITS(BA_BITS), .CA_BITS(CA_BITS)
  ) u_cfg (
    .clk_i(clk_i), .rst_i(rst_i),
    .dly_wr_i(dly_wr_i), .dly_beam_i(dly_beam_i), .dly_chan_i(dly_chan_i),
    .dly_data_i(dly_data_i), .mask_wr_i(mask_wr_i), .mask_use_i(mask_use_i),
    .mask_inv_i(mask_inv_i), .update_i(update_i), .err_clr_i(err_clr_i),
    .dly_o(w_dly), .use_o(w_use), .inv_o(w_inv), .err_o(err_o)
  );

  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NCHAN; c++)
      r_hist[c] <= {r_hist[c][DEPTH-2:0], data_i[c]};
  end

  // Re-index the history by sample age: age 0 is the newest stored sample.
  for (genvar c = 0; c < NCHAN; c++) begin : g_age_c
    for (genvar k = 0; k < DEPTH; k++) begin : g_age_k
      for (genvar s = 0; s < NSAMP; s++) begin : g_age_s
        assign w_age[c][k*NSAMP + NSAMP-1-s] = r_hist[c][k][s*NBITS +: NBITS];
      end
    end
  end

  for (genvar b = 0; b < NBEAMS; b++) begin : g_b
    for (genvar c = 0; c < NCHAN; c++) begin : g_c
      for (genvar s = 0; s < NSAMP; s++) begin : g_s
        logic [AGE_BITS-1:0] w_sel;
        logic [NBITS-1:0]    w_smp;
        assign w_sel = AGE_BITS'(w_dly[b][c]) + AGE_BITS'(NSAMP-1-s);
        assign w_smp = w_age[c][w_sel];
        assign w_mux[b][c][s*NBITS +: NBITS] =
          !w_use[b][c] ? MID : (w_inv[b][c] ? ~w_smp : w_smp);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_beams <= '0;
      r_fill  <= '0;
    end else begin
      r_beams <= w_mux;
      if (r_fill != FULL) r_fill <= r_fill + 1'b1;
    end
  end

  assign beams_o = r_beams;
  assign valid_o = (r_fill == FULL);
endmodule

// File: tb/tb_lf_beam_delay_align.sv
// Directed bench: ramp input, delay/mask programming, error flag and reset refill.
module tb_lf_beam_delay_align;
  localparam int NB   = 3;
  localparam int NC   = 8;
  localparam int NS   = 4;
  localparam int NBT  = 5;
  localparam int DP   = 22;
  localparam int MAXD = (DP-1)*NS;
  localparam int DB   = $clog2(MAXD+1);
  localparam int BAB  = 2;
  localparam int CAB  = 3;
  localparam int WW   = NS*NBT;

  logic                           clk_i = 1'b0;
  logic                           rst_i;
  logic [NC-1:0][WW-1:0]          data_i;
  logic                           dly_wr_i, mask_wr_i, update_i, err_clr_i;
  logic [BAB-1:0]                 dly_beam_i;
  logic [CAB-1:0]                 dly_chan_i;
  logic [DB-1:0]                  dly_data_i;
  logic [NC-1:0]                  mask_use_i, mask_inv_i;
  logic [NB-1:0][NC-1:0][WW-1:0]  beams_o;
  logic                           valid_o, err_o;

  int checks = 0;
  int errors = 0;
  int t = 0;

  always #5 clk_i = ~clk_i;

  lf_beam_delay_align #(.NBEAMS(NB), .NCHAN(NC), .NSAMP(NS), .NBITS(NBT), .DEPTH(DP)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i),
    .dly_wr_i(dly_wr_i), .dly_beam_i(dly_beam_i), .dly_chan_i(dly_chan_i),
    .dly_data_i(dly_data_i), .mask_wr_i(mask_wr_i), .mask_use_i(mask_use_i),
    .mask_inv_i(mask_inv_i), .update_i(update_i), .err_clr_i(err_clr_i),
    .beams_o(beams_o), .valid_o(valid_o), .err_o(err_o)
  );

  // Ramp: sample at absolute index n on channel c is (n + c) mod 32.
  function automatic logic [WW-1:0] ramp_word(input int tt, input int c);
    logic [WW-1:0] w;
    for (int s = 0; s < NS; s++) w[s*NBT +: NBT] = NBT'((NS*tt + s + c) & 31);
    return w;
  endfunction

  task automatic drive_data();
    for (int c = 0; c < NC; c++) data_i[c] = ramp_word(t, c);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
    t++;
    drive_data();
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Output word seen now was selected from data two words back, minus d samples.
  task automatic chk_word(input string tag, input int b, input int c, input int d,
                          input bit use_b, input bit inv_b);
    logic [WW-1:0]  exp;
    logic [NBT-1:0] v;
    for (int s = 0; s < NS; s++) begin
      v = NBT'((NS*(t-2) + s - d + c) & 31);
      if (!use_b)     v = 5'd16;
      else if (inv_b) v = ~v;
      exp[s*NBT +: NBT] = v;
    end
    checks++;
    assert (beams_o[b][c] === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, beams_o[b][c], exp);
    end
  endtask

  task automatic wr_dly(input int b, input int c, input int d, input bit with_upd);
    dly_wr_i = 1'b1; dly_beam_i = BAB'(b); dly_chan_i = CAB'(c); dly_data_i = DB'(d);
    update_i = with_upd;
    step();
    dly_wr_i = 1'b0; update_i = 1'b0;
  endtask

  task automatic upd();
    update_i = 1'b1;
    step();
    update_i = 1'b0;
    step();
    step();
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      step();
      n = i;
      if (valid_o) break;
    end
    checks++;
    assert (n == DP+1 && valid_o === 1'b1) else begin
      errors++;
      $error("FAIL %s: observed %0d clocks expected %0d", tag, n, DP+1);
    end
  endtask

  initial begin
    rst_i = 1'b1; dly_wr_i = 1'b0; mask_wr_i = 1'b0; update_i = 1'b0; err_clr_i = 1'b0;
    dly_beam_i = '0; dly_chan_i = '0; dly_data_i = '0; mask_use_i = '1; mask_inv_i = '0;
    drive_data();
    step(); step();
    checks++;
    assert (beams_o === '0) else begin
      errors++; $error("FAIL rst_beams: observed %h expected 0", beams_o);
    end
    chk_bit("rst_valid", valid_o, 1'b0);
    chk_bit("rst_err", err_o, 1'b0);

    rst_i = 1'b0;
    wait_valid("fill_time");
    chk_word("d0_b0c0", 0, 0, 0, 1, 0);
    chk_word("d0_b2c5", 2, 5, 0, 1, 0);

    wr_dly(1, 3, 5, 0);
    upd();
    chk_word("d5_b1c3", 1, 3, 5, 1, 0);
    chk_word("d0_b1c2", 1, 2, 0, 1, 0);
    chk_bit("upd_valid", valid_o, 1'b1);

    wr_dly(1, 3, MAXD, 0);
    upd();
    chk_word("dmax_b1c3", 1, 3, MAXD, 1, 0);
    chk_bit("dmax_noerr", err_o, 1'b0);

    wr_dly(0, 7, 100, 0);
    chk_bit("clamp_err", err_o, 1'b1);
    upd();
    chk_word("clamp_b0c7", 0, 7, MAXD, 1, 0);
    err_clr_i = 1'b1; step(); err_clr_i = 1'b0;
    chk_bit("err_clr", err_o, 1'b0);

    wr_dly(3, 7, 9, 0);
    chk_bit("badbeam_err", err_o, 1'b1);
    upd();
    chk_word("badbeam_b0c7", 0, 7, MAXD, 1, 0);
    chk_word("badbeam_b1c7", 1, 7, 0, 1, 0);
    chk_word("badbeam_b2c7", 2, 7, 0, 1, 0);
    err_clr_i = 1'b1; step(); err_clr_i = 1'b0;
    chk_bit("err_clr2", err_o, 1'b0);

    mask_wr_i = 1'b1; dly_beam_i = 2'd3; mask_use_i = 8'h00; mask_inv_i = 8'hFF;
    step(); mask_wr_i = 1'b0;
    chk_bit("badmask_err", err_o, 1'b1);
    err_clr_i = 1'b1; step(); err_clr_i = 1'b0;
    chk_bit("err_clr3", err_o, 1'b0);

    dly_wr_i = 1'b1; dly_beam_i = 2'd2; dly_chan_i = 3'd1; dly_data_i = DB'(120);
    err_clr_i = 1'b1;
    step();
    dly_wr_i = 1'b0; err_clr_i = 1'b0;
    chk_bit("err_beats_clr", err_o, 1'b1);
    err_clr_i = 1'b1; step(); err_clr_i = 1'b0;

    mask_wr_i = 1'b1; dly_beam_i = 2'd0; mask_use_i = 8'hFE; mask_inv_i = 8'h02;
    step(); mask_wr_i = 1'b0; mask_use_i = '1; mask_inv_i = '0;
    upd();
    chk_word("mask_b0c0_mid", 0, 0, 0, 0, 0);
    chk_word("mask_b0c1_inv", 0, 1, 0, 1, 1);
    chk_word("mask_b0c2_pass", 0, 2, 0, 1, 0);
    chk_word("mask_b1c1_pass", 1, 1, 0, 1, 0);
    chk_bit("mask_noerr", err_o, 1'b0);

    wr_dly(2, 4, 7, 1);
    step(); step();
    chk_word("same_cyc_old", 2, 4, 0, 1, 0);
    upd();
    chk_word("second_upd", 2, 4, 7, 1, 0);

    rst_i = 1'b1;
    #1;
    checks++;
    assert (beams_o === '0) else begin
      errors++; $error("FAIL midrst_beams: observed %h expected 0", beams_o);
    end
    chk_bit("midrst_valid", valid_o, 1'b0);
    step(); step();
    rst_i = 1'b0;
    wait_valid("refill_time");
    chk_word("refill_b1c3_d0", 1, 3, 0, 1, 0);
    chk_word("refill_b0c7_d0", 0, 7, 0, 1, 0);
    chk_word("refill_b0c0_mask", 0, 0, 0, 1, 0);
    chk_word("refill_b0c1_mask", 0, 1, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
